matrix_xof_sched: RTL and testbench
===================================

MATRIX_XOF_SCHED -- requirements
Module: matrix_xof_sched

Interface
REQ-001 SHALL have parameter K, default 3, module rank (matrix is K x K, K in 2..4).
REQ-002 SHALL have parameter OUT_LEN, default 14'd5376, XOF output length in bits driven on xof_output_len.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max RUN cycles (used only with XOF_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all logic on its rising edge; one clock only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin generation of all K*K entries; sampled only in IDLE.
REQ-007 rho  input  256  public seed; captured on accepted start.
REQ-008 transpose  input  1  ordering select; captured on accepted start.
REQ-009 xof_rst  output  1  reset to shake128 instance.
REQ-010 xof_enable  output  1  enable to shake128 instance.
REQ-011 xof_in  output  272  absorbed message rho||b0||b1.
REQ-012 xof_domain  output  4  constant 4'b1111.
REQ-013 xof_output_len  output  14  constant OUT_LEN.
REQ-014 xof_done  input  1  shake128 done flag.
REQ-015 out_valid  output  1  shake128 output_string holds entry (out_i, out_j).
REQ-016 out_ready  input  1  consumer has taken the current entry.
REQ-017 out_i, out_j  output  2 each  matrix indices of current entry.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 done  output  1  one-cycle pulse after last entry consumed.
REQ-020 err  output  1  sticky timeout flag (XOF_TIMEOUT_EN only; else tied 0).

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN, HOLD, FIN.
REQ-022 IDLE: start=1 -> capture rho/transpose, i=0, j=0, go LOAD next cycle; start ignored in all other states.
REQ-023 LOAD: exactly one cycle, xof_rst=1, xof_enable=0, xof_in stable; -> RUN.
REQ-024 RUN: xof_rst=0, xof_enable=1 until xof_done sampled 1; -> HOLD. xof_done in LOAD SHALL be ignored.
REQ-025 HOLD: out_valid=1, xof_enable=0, xof_in held; out_valid SHALL stay 1 until out_ready=1.
REQ-026 HOLD with out_ready=1: if (i,j)=(K-1,K-1) -> FIN, else advance j (wrap to 0 and increment i when j=K-1) -> LOAD.
REQ-027 FIN: done=1 for exactly one cycle; -> IDLE.
REQ-028 Entry order SHALL be row-major: (0,0),(0,1)..(K-1,K-1); exactly K*K LOAD cycles per start.
REQ-029 xof_in[255:0]=rho; transpose=0: xof_in[263:256]=j, [271:264]=i; transpose=1: [263:256]=i, [271:264]=j (indices zero-extended to 8 bits).
REQ-030 out_i/out_j SHALL equal the indices used for the message in flight; valid whenever out_valid=1.
REQ-031 Minimum per-entry latency: LOAD(1) + RUN(shake128 cycles) + HOLD(≥1).

Reset
REQ-032 rst=1 SHALL force IDLE next edge from any state, aborting mid-operation with no done pulse.
REQ-033 Reset values: xof_rst=1, xof_enable=0, out_valid=0, done=0, busy=0, err=0, out_i=0, out_j=0, xof_in=0.
REQ-034 While in IDLE after reset, xof_rst SHALL stay 1 (shake128 held in reset when unused).

Configuration
REQ-035 Macro XOF_TIMEOUT_EN defined: cycle counter in RUN; reaching TIMEOUT without xof_done sets err=1, drops xof_enable, returns to IDLE without done; err cleared only by rst or next accepted start.
REQ-036 XOF_TIMEOUT_EN undefined: no counter, RUN waits indefinitely, err tied 0.

Verification
REQ-037 rho=256'hf8f1...5598, transpose=0, out_ready=1 always -> 9 LOAD pulses, xof_in[271:256] sequence 16'h0000,0001,0002,0100,..,0202; single done pulse.
REQ-038 Same rho, transpose=1 -> entry (0,1) shows xof_in[271:256]=16'h0100; (2,0) shows 16'h0002.
REQ-039 out_ready held 0 for 20 cycles in HOLD of (1,1) -> out_valid, out_i=1, out_j=1, xof_in stable all 20 cycles; no new LOAD.
REQ-040 rst asserted during RUN of entry (1,2) -> next cycle IDLE, xof_rst=1, busy=0, no done; new start restarts at (0,0).
REQ-041 start pulsed while busy -> ignored; entry count still 9.
REQ-042 XOF_TIMEOUT_EN, TIMEOUT=16, xof_done stuck 0 -> err=1 after 16 RUN cycles, IDLE, done never asserted.

Source files
------------

// File: rtl/matrix_xof_sched.sv
// ----------------------------------------------------------------------------
// matrix_xof_sched
//
// Walks the K x K public matrix in row-major order and, for each entry (i,j),
// drives one shake128 instance through a reset / absorb-squeeze / hold cycle.
// The absorbed message is rho || b0 || b1, where (b0,b1) = (j,i) normally and
// (i,j) when transpose is set. The consumer reads the squeezed bytes directly
// from shake128's output_string while out_valid is high.
//
// Optional feature (macro XOF_TIMEOUT_EN): bounds the RUN phase to TIMEOUT
// cycles. On expiry err is set (sticky) and the scheduler returns to IDLE
// without a done pulse. Without the macro RUN waits indefinitely, err = 0.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start             begin a K*K job (sampled only in IDLE)
//   rho[255:0]        seed, captured with start
//   transpose         index ordering select, captured with start
//   xof_rst           reset to shake128 (high in IDLE, LOAD, FIN)
//   xof_enable        enable to shake128 (high in RUN)
//   xof_in[271:0]     absorbed message
//   xof_domain[3:0]   constant 4'b1111
//   xof_output_len    constant OUT_LEN
//   xof_done          shake128 done flag
//   out_valid         entry (out_i,out_j) is available on output_string
//   out_ready         consumer has taken the current entry
//   out_i, out_j      indices of the entry in flight
//   busy              high in any state except IDLE
//   done              one-cycle pulse after the last entry was consumed
//   err               sticky timeout flag
//   dbg_state[2:0]    current FSM state (IDLE=0 LOAD=1 RUN=2 HOLD=3 FIN=4)
//
// Handshake: an entry transfers on the rising edge where out_valid and
// out_ready are both 1. out_valid, out_i, out_j and xof_in do not change
// while out_valid is high and out_ready is low.
// ----------------------------------------------------------------------------
module matrix_xof_sched #(
    parameter int          K       = 3,
    parameter logic [13:0] OUT_LEN = 14'd5376,
    parameter int          TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] rho,
    input  logic         transpose,
    output logic         xof_rst,
    output logic         xof_enable,
    output logic [271:0] xof_in,
    output logic [3:0]   xof_domain,
    output logic [13:0]  xof_output_len,
    input  logic         xof_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_i,
    output logic [1:0]   out_j,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [2:0]   dbg_state
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    localparam logic [1:0] KM1 = 2'(K - 1);

    logic [2:0]   state_q, state_d;
    logic [1:0]   i_q, i_d;
    logic [1:0]   j_q, j_d;
    logic [255:0] rho_q, rho_d;
    logic         tr_q, tr_d;

`ifdef XOF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    // TIMEOUT only matters when the timeout feature is built in.
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rho_d   = rho_q;
        tr_d    = tr_q;
`ifdef XOF_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    rho_d   = rho;
                    tr_d    = transpose;
                    i_d     = 2'd0;
                    j_d     = 2'd0;
                    state_d = LOAD;
`ifdef XOF_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                // xof_done is deliberately not looked at here: a stale flag
                // from the previous entry must not short-circuit RUN.
                state_d = RUN;
`ifdef XOF_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RUN: begin
                if (xof_done) begin
                    state_d = HOLD;
                end
`ifdef XOF_TIMEOUT_EN
                // cnt_q counts completed RUN cycles; this is the TIMEOUT-th.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    if (i_q == KM1 && j_q == KM1) begin
                        state_d = FIN;
                    end else begin
                        if (j_q == KM1) begin
                            j_d = 2'd0;
                            i_d = i_q + 2'd1;
                        end else begin
                            j_d = j_q + 2'd1;
                        end
                        state_d = LOAD;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            rho_q   <= '0;
            tr_q    <= 1'b0;
`ifdef XOF_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rho_q   <= rho_d;
            tr_q    <= tr_d;
`ifdef XOF_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // shake128 is kept in reset whenever it is not computing or holding a
    // result, so an idle or finished scheduler never leaves it running.
    assign xof_rst        = (state_q == IDLE) || (state_q == LOAD) || (state_q == FIN);
    assign xof_enable     = (state_q == RUN);
    assign xof_in         = tr_q ? {6'd0, j_q, 6'd0, i_q, rho_q}
                                 : {6'd0, i_q, 6'd0, j_q, rho_q};
    assign xof_domain     = 4'b1111;
    assign xof_output_len = OUT_LEN;
    assign out_valid      = (state_q == HOLD);
    assign out_i          = i_q;
    assign out_j          = j_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
    assign dbg_state      = state_q;
`ifdef XOF_TIMEOUT_EN
    assign err            = err_q;
`else
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_xof_sched.sv
// ----------------------------------------------------------------------------
// tb_matrix_xof_sched
//
// Directed bench for matrix_xof_sched (K=3). A small shake128 stand-in raises
// xof_done after LAT enabled cycles. A negedge monitor checks every LOAD
// message and every handshake against expected queues filled from
// hand-written tag tables. Build with +define+XOF_TIMEOUT_EN to exercise the
// timeout path (TIMEOUT=16).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_xof_sched;

    localparam int K   = 3;
    localparam int LAT = 3;
    localparam int TO  = 16;

    localparam logic [255:0] RHO_A =
        256'hf8f1_3a6c_0d27_9be4_51c8_7f02_e6a9_34bd_1c85_fe70_29d3_b64a_07e1_c95f_6b2a_5598;
    localparam logic [255:0] RHO_B =
        256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_a5a5_5a5a_c3c3_3c3c_dead_beef_cafe_f00d;

    // Expected xof_in[271:256] per row-major entry, worked out by hand.
    logic [15:0] tag_n [9] = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101,
                               16'h0102, 16'h0200, 16'h0201, 16'h0202};
    logic [15:0] tag_t [9] = '{16'h0000, 16'h0100, 16'h0200, 16'h0001, 16'h0101,
                               16'h0201, 16'h0002, 16'h0102, 16'h0202};

    logic         clk = 1'b0;
    logic         rst, start, transpose, xof_done, out_ready;
    logic [255:0] rho;
    logic         xof_rst, xof_enable, out_valid, busy, done, err;
    logic [271:0] xof_in;
    logic [3:0]   xof_domain;
    logic [13:0]  xof_output_len;
    logic [1:0]   out_i, out_j;
    logic [2:0]   dbg_state;

    matrix_xof_sched #(.K(K), .OUT_LEN(14'd5376), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rho(rho), .transpose(transpose),
        .xof_rst(xof_rst), .xof_enable(xof_enable), .xof_in(xof_in),
        .xof_domain(xof_domain), .xof_output_len(xof_output_len),
        .xof_done(xof_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_j(out_j), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    logic [271:0] exp_q[$];
    logic [3:0]   exp_ij_q[$];
    logic [271:0] mon_e;
    logic [3:0]   mon_ij;

    task automatic chk(input string tag, input logic [271:0] act, input logic [271:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- shake128 stand-in ----------------
    int rsp_cnt = 0;
    bit done_stuck0 = 1'b0;
    bit done_early = 1'b0;
    always @(posedge clk) begin
        #1;
        if (xof_enable && !done_stuck0) begin
            rsp_cnt++;
            xof_done = (rsp_cnt >= LAT);
        end else begin
            rsp_cnt = 0;
            // done_early leaves the flag high while shake128 is in reset.
            xof_done = done_early && xof_rst;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (xof_enable) en_cnt++;
            if (done) done_cnt++;
            if (xof_rst && busy && !done) begin
                load_cnt++;
                chk("load_en", 272'(xof_enable), 272'(0));
                mon_e = '1;
                if (exp_q.size() != 0) mon_e = exp_q.pop_front();
                chk("load_msg", xof_in, mon_e);
            end
            if (out_valid) begin
                chk("hold_en", 272'(xof_enable), 272'(0));
                if (out_ready) begin
                    mon_ij = 4'hf;
                    if (exp_ij_q.size() != 0) mon_ij = exp_ij_q.pop_front();
                    chk("hs_idx", 272'({out_i, out_j}), 272'(mon_ij));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_job(input logic [255:0] r, input logic tr, input int n_ent);
        for (int n = 0; n < n_ent; n++) begin
            exp_q.push_back({(tr ? tag_t[n] : tag_n[n]), r});
            exp_ij_q.push_back({2'(n / K), 2'(n % K)});
        end
    endtask

    task automatic kick(input logic [255:0] r, input logic tr);
        rho = r;
        transpose = tr;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble the inputs so only the captured copies can be in use.
        rho = {8{$urandom()}};
        transpose = ~tr;
    endtask

    task automatic run_job(input logic [255:0] r, input logic tr, input int stall_n, input bit poke);
        int l0, d0, e0, stalled, l_stall;
        bit fin;
        l0 = load_cnt; d0 = done_cnt; e0 = en_cnt;
        stalled = 0; l_stall = 0; fin = 1'b0;
        push_job(r, tr, K * K);
        kick(r, tr);
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            start = poke && (cyc == 4 || cyc == 25);
            if (out_valid && out_i == 2'd1 && out_j == 2'd1 && stalled < stall_n) begin
                if (stalled == 0) l_stall = load_cnt;
                out_ready = 1'b0;
                chk("stall_msg", xof_in, {tr ? tag_t[4] : tag_n[4], r});
                chk("stall_loads", 272'(load_cnt), 272'(l_stall));
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (done_cnt != d0) fin = 1'b1;
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("job_finished", 272'(fin), 272'(1));
        chk("job_loads", 272'(load_cnt - l0), 272'(K * K));
        chk("job_dones", 272'(done_cnt - d0), 272'(1));
        chk("job_run_cycles", 272'(en_cnt - e0), 272'(K * K * LAT));
        chk("job_q_empty", 272'(exp_q.size() + exp_ij_q.size()), 272'(0));
        chk("job_idle", 272'(busy), 272'(0));
        if (stall_n > 0) chk("stall_len", 272'(stalled), 272'(stall_n));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, l0, e0, cyc;
        bit hit;
        rst = 1'b1; start = 1'b0; rho = '0; transpose = 1'b0; out_ready = 1'b1;
        xof_done = 1'b0;
        repeat (3) tick();

        // Reset values.
        chk("rst_xof_rst", 272'(xof_rst), 272'(1));
        chk("rst_xof_en", 272'(xof_enable), 272'(0));
        chk("rst_valid", 272'(out_valid), 272'(0));
        chk("rst_done", 272'(done), 272'(0));
        chk("rst_busy", 272'(busy), 272'(0));
        chk("rst_err", 272'(err), 272'(0));
        chk("rst_ij", 272'({out_i, out_j}), 272'(0));
        chk("rst_xof_in", xof_in, 272'(0));
        chk("rst_state", 272'(dbg_state), 272'(0));
        chk("domain", 272'(xof_domain), 272'(4'hf));
        chk("out_len", 272'(xof_output_len), 272'(14'd5376));
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_xof_rst", 272'(xof_rst), 272'(1));
        chk("idle_busy", 272'(busy), 272'(0));

        // Plain row-major walk, transpose = 0.
        run_job(RHO_A, 1'b0, 0, 1'b0);

        // Transposed walk with xof_done left high while shake128 is in reset.
        done_early = 1'b1;
        run_job(RHO_A, 1'b1, 0, 1'b0);
        done_early = 1'b0;

        // Consumer stalls 20 cycles on entry (1,1).
        run_job(RHO_B, 1'b0, 20, 1'b0);

        // start pulses while busy must be ignored.
        run_job(RHO_B, 1'b1, 0, 1'b1);

        // Reset during RUN of entry (1,2).
        d0 = done_cnt;
        push_job(RHO_A, 1'b0, K * K);
        kick(RHO_A, 1'b0);
        hit = 1'b0;
        for (cyc = 0; cyc < 500 && !hit; cyc++) begin
            if (xof_enable && out_i == 2'd1 && out_j == 2'd2) hit = 1'b1;
            else tick();
        end
        chk("abort_reached", 272'(hit), 272'(1));
        rst = 1'b1;
        tick();
        chk("abort_busy", 272'(busy), 272'(0));
        chk("abort_xof_rst", 272'(xof_rst), 272'(1));
        chk("abort_xof_en", 272'(xof_enable), 272'(0));
        chk("abort_done", 272'(done), 272'(0));
        chk("abort_state", 272'(dbg_state), 272'(0));
        rst = 1'b0;
        exp_q.delete();
        exp_ij_q.delete();
        l0 = load_cnt;
        repeat (5) tick();
        chk("abort_no_done", 272'(done_cnt - d0), 272'(0));
        chk("abort_no_load", 272'(load_cnt - l0), 272'(0));
        run_job(RHO_B, 1'b1, 0, 1'b0);

        // shake128 never finishes.
        done_stuck0 = 1'b1;
        d0 = done_cnt; l0 = load_cnt; e0 = en_cnt;
        push_job(RHO_A, 1'b0, 1);
`ifdef XOF_TIMEOUT_EN
        kick(RHO_A, 1'b0);
        for (cyc = 0; cyc < 200 && busy; cyc++) tick();
        chk("to_idle", 272'(busy), 272'(0));
        chk("to_run_cycles", 272'(en_cnt - e0), 272'(TO));
        chk("to_err", 272'(err), 272'(1));
        chk("to_xof_rst", 272'(xof_rst), 272'(1));
        chk("to_no_done", 272'(done_cnt - d0), 272'(0));
        chk("to_loads", 272'(load_cnt - l0), 272'(1));
        repeat (3) tick();
        chk("to_err_sticky", 272'(err), 272'(1));
        exp_ij_q.delete();
        done_stuck0 = 1'b0;
        run_job(RHO_B, 1'b0, 0, 1'b0);
        chk("to_err_cleared", 272'(err), 272'(0));
`else
        kick(RHO_A, 1'b0);
        repeat (100) tick();
        chk("wait_busy", 272'(busy), 272'(1));
        chk("wait_xof_en", 272'(xof_enable), 272'(1));
        chk("wait_err", 272'(err), 272'(0));
        chk("wait_loads", 272'(load_cnt - l0), 272'(1));
        chk("wait_no_done", 272'(done_cnt - d0), 272'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ij_q.delete();
        done_stuck0 = 1'b0;
        tick();
        chk("wait_rst_idle", 272'(busy), 272'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
